bus_array_reg: RTL and testbench

Parametrised, registered array of `DEPTH` buses, each `WIDTH` bits wide, loaded from one input bus. Four write modes: single-entry addressed write, broadcast, shift-in and rotate. Every entry is exposed in parallel on a flattened output, with a per-entry valid mask, a valid count and a registered random-access read port. It generalises the fixed 4×4 combinational bus fan-out used in the sample designs into a stateful, configurable storage block.

---
 rtl/bus_array_pkg.sv | 24 ++
 rtl/bus_array_popcount.sv | 20 ++
 rtl/bus_array_reg.sv | 122 ++++++++++++
 tb/tb_bus_array_reg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_array_pkg.sv
// Shared types and helpers for the bus array register block.
// Mode encoding and a log2 helper for derived widths.
package bus_array_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE,
    MODE_BCAST,
    MODE_SHIFT,
    MODE_ROTATE
  } bus_mode_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_array_popcount.sv
// Population count of an N-bit vector.
// Purely combinational; count width is derived from N.
module bus_array_popcount
  import bus_array_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/bus_array_reg.sv
// Registered array of DEPTH buses with single, broadcast,
// shift and rotate writes plus a registered read port.
module bus_array_reg
  import bus_array_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = clog2(DEPTH),
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [1:0]             mode,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       in0,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [DEPTH*WIDTH-1:0] res,
  output logic [DEPTH-1:0]       valid,
  output logic [CW-1:0]          count,
  output logic                   wr_err
);

  logic [WIDTH-1:0] ent    [DEPTH];
  logic [WIDTH-1:0] ent_nx [DEPTH];
  logic [DEPTH-1:0] vld_nx;
  logic [WIDTH-1:0] rd_nx;
  logic             err_nx;
  logic             wr_hit;
  bus_mode_t        mode_e;

  assign mode_e = bus_mode_t'(mode);

  always_comb begin
    ent_nx = ent;
    vld_nx = valid;
    err_nx = 1'b0;
    wr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (AW'(i) == wr_addr) wr_hit = 1'b1;
    end
    if (wr_en) begin
      unique case (mode_e)
        MODE_SINGLE: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (AW'(i) == wr_addr) begin
              ent_nx[i] = in0;
              vld_nx[i] = 1'b1;
            end
          end
          err_nx = !wr_hit;
        end
        MODE_BCAST: begin
          for (int i = 0; i < DEPTH; i++) begin
            ent_nx[i] = in0;
          end
          vld_nx = '1;
        end
        MODE_SHIFT: begin
          for (int i = 1; i < DEPTH; i++) begin
            ent_nx[i] = ent[i-1];
          end
          ent_nx[0] = in0;
          vld_nx = {valid[DEPTH-2:0], 1'b1};
        end
        MODE_ROTATE: begin
          for (int i = 1; i < DEPTH; i++) begin
            ent_nx[i] = ent[i-1];
          end
          ent_nx[0] = ent[DEPTH-1];
          vld_nx = {valid[DEPTH-2:0], valid[DEPTH-1]};
        end
        default: ;
      endcase
    end
  end

  // Out-of-range read addresses return zero.
  always_comb begin
    rd_nx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (AW'(i) == rd_addr) rd_nx = ent[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      valid   <= '0;
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      valid   <= '0;
      rd_data <= rd_nx;
      wr_err  <= 1'b0;
    end else begin
      ent     <= ent_nx;
      valid   <= vld_nx;
      rd_data <= rd_nx;
      wr_err  <= err_nx;
    end
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      res[i*WIDTH +: WIDTH] = ent[i];
    end
  end

  bus_array_popcount #(
    .N  (DEPTH),
    .CW (CW)
  ) u_pop (
    .bits  (valid),
    .count (count)
  );

endmodule

// File: tb/tb_bus_array_reg.sv
// Directed bench for bus_array_reg, DEPTH=4 and DEPTH=3 instances.
// Inputs are shared; each step checks hand-computed results.
module tb_bus_array_reg;
  import bus_array_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic [1:0]  mode;
  logic [1:0]  wr_addr;
  logic [3:0]  in0;
  logic [1:0]  rd_addr;

  logic [3:0]  rd4;
  logic [15:0] res4;
  logic [3:0]  vld4;
  logic [2:0]  cnt4;
  logic        err4;

  logic [3:0]  rd3;
  logic [11:0] res3;
  logic [2:0]  vld3;
  logic [1:0]  cnt3;
  logic        err3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bus_array_reg u4 (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .mode    (mode),
    .wr_addr (wr_addr),
    .in0     (in0),
    .rd_addr (rd_addr),
    .rd_data (rd4),
    .res     (res4),
    .valid   (vld4),
    .count   (cnt4),
    .wr_err  (err4)
  );

  bus_array_reg #(.WIDTH(4), .DEPTH(3)) u3 (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .mode    (mode),
    .wr_addr (wr_addr),
    .in0     (in0),
    .rd_addr (rd_addr),
    .rd_data (rd3),
    .res     (res3),
    .valid   (vld3),
    .count   (cnt3),
    .wr_err  (err3)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bus_mode_t m,
                    input logic [1:0] a,
                    input logic [3:0] d);
    wr_en   = 1'b1;
    mode    = m;
    wr_addr = a;
    in0     = d;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0;
    mode = 2'd0; wr_addr = 2'd0; in0 = 4'h0; rd_addr = 2'd0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_res", res4, 16'h0000);
    chk("rst_valid", vld4, 4'h0);
    chk("rst_count", cnt4, 3'd0);
    chk("rst_rd", rd4, 4'h0);
    chk("rst_err", err4, 1'b0);

    wr(MODE_BCAST, 2'd0, 4'hA);
    cyc();
    chk("bcast_res", res4, 16'hAAAA);
    chk("bcast_valid", vld4, 4'hF);
    chk("bcast_count", cnt4, 3'd4);

    do_reset();
    wr(MODE_SINGLE, 2'd2, 4'h5);
    rd_addr = 2'd2;
    cyc();
    chk("single_res", res4, 16'h0500);
    chk("single_valid", vld4, 4'b0100);
    chk("single_count", cnt4, 3'd1);
    chk("single_rd_old", rd4, 4'h0);
    wr(MODE_SINGLE, 2'd2, 4'h7);
    cyc();
    chk("rbw_rd", rd4, 4'h5);
    chk("rbw_res", res4, 16'h0700);
    wr_en = 1'b0;
    cyc();
    chk("rd_new", rd4, 4'h7);

    do_reset();
    wr(MODE_SHIFT, 2'd0, 4'h1);
    cyc();
    chk("sh1_res", res4, 16'h0001);
    chk("sh1_count", cnt4, 3'd1);
    wr(MODE_SHIFT, 2'd0, 4'h2);
    cyc();
    chk("sh2_res", res4, 16'h0012);
    chk("sh2_count", cnt4, 3'd2);
    wr(MODE_SHIFT, 2'd0, 4'h3);
    cyc();
    chk("sh3_res", res4, 16'h0123);
    chk("sh3_count", cnt4, 3'd3);
    chk("sh3_valid", vld4, 4'b0111);
    wr(MODE_SHIFT, 2'd0, 4'h4);
    cyc();
    chk("sh4_res", res4, 16'h1234);
    chk("sh4_count", cnt4, 3'd4);
    wr(MODE_ROTATE, 2'd0, 4'hF);
    cyc();
    chk("rot_res", res4, 16'h2341);
    chk("rot_valid", vld4, 4'hF);

    do_reset();
    wr(MODE_SHIFT, 2'd0, 4'h8);
    cyc();
    wr(MODE_ROTATE, 2'd0, 4'h0);
    cyc();
    chk("rot_part_res", res4, 16'h0080);
    chk("rot_part_valid", vld4, 4'b0010);
    cyc();
    cyc();
    cyc();
    chk("rot_wrap_res", res4, 16'h0008);
    chk("rot_wrap_valid", vld4, 4'b0001);

    do_reset();
    wr(MODE_SINGLE, 2'd3, 4'h5);
    cyc();
    chk("d3_err_hi", err3, 1'b1);
    chk("d3_res", res3, 12'h000);
    chk("d3_valid", vld3, 3'b000);
    chk("d4_noerr", err4, 1'b0);
    chk("d4_write", res4, 16'h5000);
    wr_en = 1'b0;
    cyc();
    chk("d3_err_lo", err3, 1'b0);
    wr(MODE_BCAST, 2'd0, 4'h6);
    rd_addr = 2'd3;
    cyc();
    chk("d3_bcast", res3, 12'h666);
    chk("d3_count", cnt3, 2'd3);
    wr_en = 1'b0;
    cyc();
    chk("d3_rd_oor", rd3, 4'h0);
    rd_addr = 2'd2;
    cyc();
    chk("d3_rd2", rd3, 4'h6);

    clr = 1'b1;
    wr(MODE_BCAST, 2'd0, 4'hB);
    cyc();
    chk("clr_res", res4, 16'h0000);
    chk("clr_count", cnt4, 3'd0);
    chk("clr_valid", vld4, 4'h0);
    chk("clr_err", err4, 1'b0);
    wr(MODE_SINGLE, 2'd3, 4'h1);
    cyc();
    chk("clr_d3_noerr", err3, 1'b0);
    chk("clr_d3_res", res3, 12'h000);
    clr = 1'b0;

    wr(MODE_SHIFT, 2'd0, 4'h3);
    cyc();
    wr(MODE_SHIFT, 2'd0, 4'h4);
    cyc();
    chk("pre_rst_res", res4, 16'h0034);
    rst = 1'b1;
    wr(MODE_SHIFT, 2'd0, 4'h5);
    cyc();
    rst = 1'b0;
    chk("mid_rst_res", res4, 16'h0000);
    chk("mid_rst_valid", vld4, 4'h0);
    chk("mid_rst_count", cnt4, 3'd0);
    wr(MODE_SHIFT, 2'd0, 4'h9);
    cyc();
    chk("post_rst_res", res4, 16'h0009);
    chk("post_rst_valid", vld4, 4'b0001);
    chk("post_rst_count", cnt4, 3'd1);
    wr_en = 1'b0;
    cyc();
    chk("hold_res", res4, 16'h0009);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
